// File: rtl/imem_arbiter_if.sv
// imem_arbiter_if: fetch, loader and instruction-RAM port signals.
// master: arbiter view; slave: pipeline / loader / RAM view.
interface imem_arbiter_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic              hlt;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_gnt;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_rdata;
  logic              hold_pc;
  logic              load_req;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_wdata;
  logic              load_last;
  logic              load_gnt;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic              flush;

  modport master (
    input  hlt, fetch_req, fetch_addr,
    input  load_req, load_addr, load_wdata,
    input  load_last, mem_rdata,
    output fetch_gnt, fetch_valid, fetch_rdata,
    output hold_pc, load_gnt, mem_en, mem_we,
    output mem_addr, mem_wdata, busy, flush
  );

  modport slave (
    output hlt, fetch_req, fetch_addr,
    output load_req, load_addr, load_wdata,
    output load_last, mem_rdata,
    input  fetch_gnt, fetch_valid, fetch_rdata,
    input  hold_pc, load_gnt, mem_en, mem_we,
    input  mem_addr, mem_wdata, busy, flush
  );
endinterface

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares the single-port IMEM between fetch and loader.
// Ports: i_clk, i_rst_n (sync, active-low), io_bus (imem_arbiter_if.master).
// Option IMEM_LOAD_FLUSH_EN: one-cycle flush pulse after each LOAD exit.
module imem_arbiter #(
  parameter int ADDR_W       = 6,
  parameter int DATA_W       = 32,
  parameter int MAX_BURST    = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  imem_arbiter_if.master io_bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2
  } state_t;

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int BW = $clog2(MAX_BURST) + 1;
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [SW-1:0] STARVE_GO  = SW'(STARVE_LIMIT - 1);
  localparam logic [BW-1:0] BURST_END  = BW'(MAX_BURST - 1);
  localparam logic [DATA_W-1:0] NOP    = DATA_W'(32'h0000_0013);

  state_t          r_state;
  logic [SW-1:0]   r_starve;
  logic [BW-1:0]   r_burst;
  logic            r_fvalid;

  logic              w_freq;
  logic              w_fgnt;
  logic              w_lgnt;
  logic              w_load_go;
  logic              w_load_end;
  logic              w_load_exit;
  logic              w_fvalid_d;
  logic [ADDR_W-1:0] w_addr;

  // A halted core never requests.
  assign w_freq = io_bus.fetch_req & ~io_bus.hlt;

  // Grants are masked during reset so the reset-cycle write is dropped.
  assign w_fgnt = i_rst_n & (r_state == FETCH) & w_freq;
  assign w_lgnt = i_rst_n & (r_state == LOAD) & io_bus.load_req;

  // Loader wins when fetch is idle or it has waited long enough.
  assign w_load_go = io_bus.load_req &
                     (~w_freq | (r_starve >= STARVE_GO));

  assign w_load_end = (w_lgnt & (io_bus.load_last |
                                 (r_burst == BURST_END))) |
                      ~io_bus.load_req;
  assign w_load_exit = (r_state == LOAD) & w_load_end;

  assign w_addr = (r_state == LOAD) ? io_bus.load_addr
                                    : io_bus.fetch_addr;

`ifdef IMEM_LOAD_FLUSH_EN
  logic r_flush;
  assign w_fvalid_d   = w_fgnt & ~w_load_exit;
  assign io_bus.flush = r_flush;
`else
  assign w_fvalid_d   = w_fgnt;
  assign io_bus.flush = 1'b0;
`endif

  assign io_bus.fetch_gnt   = w_fgnt;
  assign io_bus.load_gnt    = w_lgnt;
  assign io_bus.mem_en      = w_fgnt | w_lgnt;
  assign io_bus.mem_we      = w_lgnt;
  assign io_bus.mem_addr    = w_addr;
  assign io_bus.mem_wdata   = io_bus.load_wdata;
  assign io_bus.hold_pc     = ~i_rst_n | (w_freq & ~w_fgnt);
  assign io_bus.busy        = (r_state != IDLE);
  assign io_bus.fetch_valid = r_fvalid;
  assign io_bus.fetch_rdata = r_fvalid ? io_bus.mem_rdata : NOP;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_starve <= '0;
      r_burst  <= '0;
      r_fvalid <= 1'b0;
`ifdef IMEM_LOAD_FLUSH_EN
      r_flush  <= 1'b0;
`endif
    end else begin
      r_fvalid <= w_fvalid_d;
`ifdef IMEM_LOAD_FLUSH_EN
      r_flush  <= w_load_exit;
`endif
      unique case (r_state)
        IDLE: begin
          if (w_load_go)   r_state <= LOAD;
          else if (w_freq) r_state <= FETCH;
        end
        FETCH: begin
          if (w_load_go)
            r_state <= LOAD;
          else if (!w_freq && !io_bus.load_req)
            r_state <= IDLE;
        end
        LOAD: begin
          if (w_load_end)
            r_state <= w_freq ? FETCH : IDLE;
        end
        default: r_state <= IDLE;
      endcase

      // Starvation age; held at zero through a LOAD tenure.
      if (r_state == LOAD)
        r_starve <= '0;
      else if (!io_bus.load_req)
        r_starve <= '0;
      else if (w_load_go)
        r_starve <= '0;
      else if (r_starve != STARVE_MAX)
        r_starve <= r_starve + SW'(1);

      if (w_load_exit)
        r_burst <= '0;
      else if (w_lgnt)
        r_burst <= r_burst + BW'(1);
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed checks of imem_arbiter with a 64-word RAM.
// Inputs change and outputs are sampled around the falling edge.
module tb_imem_arbiter;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] WA  = 32'hA0A0_0001;
  localparam logic [31:0] WB  = 32'hB0B0_0002;
  localparam logic [31:0] WC  = 32'hC0C0_0003;
`ifdef IMEM_LOAD_FLUSH_EN
  localparam logic EXP_FLUSH = 1'b1;
`else
  localparam logic EXP_FLUSH = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  imem_arbiter_if bus ();

  imem_arbiter dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:63] = '{0: WA, 1: WB, 2: WC, default: 32'h0};
  logic [31:0] mrd = 32'h0;
  assign bus.mem_rdata = mrd;

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            mrd <= mem[bus.mem_addr];
    end
  end

  task automatic idle_inputs();
    bus.hlt        = 1'b0;
    bus.fetch_req  = 1'b0;
    bus.fetch_addr = '0;
    bus.load_req   = 1'b0;
    bus.load_addr  = '0;
    bus.load_wdata = '0;
    bus.load_last  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    bus.fetch_req = 1'b1;
    bus.load_req  = 1'b1;
    @(negedge clk);
    #1;
    n_cmp++;
    if ({bus.fetch_gnt, bus.load_gnt, bus.mem_en, bus.mem_we,
         bus.hold_pc} !== 5'b00001) begin
      n_err++;
      $display("FAIL rst_ctrl got=%b exp=00001",
               {bus.fetch_gnt, bus.load_gnt, bus.mem_en,
                bus.mem_we, bus.hold_pc});
    end
    n_cmp++;
    if ({bus.busy, bus.fetch_valid, bus.flush} !== 3'b000) begin
      n_err++;
      $display("FAIL rst_regs got=%b exp=000",
               {bus.busy, bus.fetch_valid, bus.flush});
    end
    n_cmp++;
    if (bus.fetch_rdata !== NOP) begin
      n_err++;
      $display("FAIL rst_nop got=%h exp=%h", bus.fetch_rdata, NOP);
    end
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_fetch();
    logic [31:0] exp_d [3];
    exp_d = '{WA, WB, WC};
    do_reset();
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 6'd0;
    #1;
    n_cmp++;
    if ({bus.hold_pc, bus.fetch_gnt, bus.fetch_valid} !== 3'b100) begin
      n_err++;
      $display("FAIL fetch_c1 got=%b exp=100",
               {bus.hold_pc, bus.fetch_gnt, bus.fetch_valid});
    end
    n_cmp++;
    if (bus.fetch_rdata !== NOP) begin
      n_err++;
      $display("FAIL fetch_c1_nop got=%h exp=%h", bus.fetch_rdata, NOP);
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if ({bus.fetch_gnt, bus.hold_pc, bus.mem_en, bus.mem_we,
           bus.mem_addr} !== {4'b1010, 6'(i)}) begin
        n_err++;
        $display("FAIL fetch_gnt%0d got=%b exp=%b", i,
                 {bus.fetch_gnt, bus.hold_pc, bus.mem_en, bus.mem_we,
                  bus.mem_addr}, {4'b1010, 6'(i)});
      end
      if (i > 0) begin
        n_cmp++;
        if (bus.fetch_rdata !== exp_d[i-1]) begin
          n_err++;
          $display("FAIL fetch_data%0d got=%h exp=%h", i - 1,
                   bus.fetch_rdata, exp_d[i-1]);
        end
      end
      @(negedge clk);
      if (i < 2) bus.fetch_addr = 6'(i + 1);
      else       bus.fetch_req  = 1'b0;
    end
    #1;
    n_cmp++;
    if ({bus.fetch_valid, bus.fetch_rdata} !== {1'b1, WC}) begin
      n_err++;
      $display("FAIL fetch_data2 got=%b/%h exp=1/%h",
               bus.fetch_valid, bus.fetch_rdata, WC);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({bus.fetch_valid, bus.busy, bus.fetch_rdata} !== {2'b00, NOP}) begin
      n_err++;
      $display("FAIL fetch_end got=%b%b/%h exp=00/%h", bus.fetch_valid,
               bus.busy, bus.fetch_rdata, NOP);
    end
    @(negedge clk);
  endtask

  task automatic test_starve();
    logic [7:0] lgv, fgv, hv;
    int idx;
    do_reset();
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 6'd5;
    @(negedge clk);
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      bus.load_req   = (idx < 2);
      bus.load_addr  = 6'(20 + idx);
      bus.load_wdata = 32'h5500_0000 + 32'(idx);
      bus.load_last  = (idx == 1);
      #1;
      lgv[c] = bus.load_gnt;
      fgv[c] = bus.fetch_gnt;
      hv[c]  = bus.hold_pc;
      if (bus.load_gnt) idx++;
      @(negedge clk);
    end
    n_cmp++;
    if (lgv !== 8'h30) begin
      n_err++;
      $display("FAIL starve_lgnt got=%b exp=%b", lgv, 8'h30);
    end
    n_cmp++;
    if (fgv !== 8'hCF) begin
      n_err++;
      $display("FAIL starve_fgnt got=%b exp=%b", fgv, 8'hCF);
    end
    n_cmp++;
    if (hv !== 8'h30) begin
      n_err++;
      $display("FAIL starve_hold got=%b exp=%b", hv, 8'h30);
    end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_burst();
    logic [31:0] wd [4];
    int idx, wes;
    wd = '{32'h11, 32'h22, 32'h33, 32'h0};
    do_reset();
    idx = 0;
    wes = 0;
    for (int c = 0; c < 4; c++) begin
      bus.load_req   = (idx < 3);
      bus.load_addr  = 6'(10 + idx);
      bus.load_wdata = wd[idx];
      bus.load_last  = (idx == 2);
      #1;
      if (bus.mem_we) wes++;
      if (bus.load_gnt) idx++;
      @(negedge clk);
    end
    bus.load_req  = 1'b0;
    bus.load_last = 1'b0;
    n_cmp++;
    if (wes !== 3) begin
      n_err++;
      $display("FAIL burst_we got=%0d exp=3", wes);
    end
    #1;
    n_cmp++;
    if ({bus.busy, bus.fetch_valid, bus.flush} !== {2'b00, EXP_FLUSH}) begin
      n_err++;
      $display("FAIL burst_exit got=%b exp=%b",
               {bus.busy, bus.fetch_valid, bus.flush},
               {2'b00, EXP_FLUSH});
    end
    @(negedge clk);
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 6'd11;
    #1;
    n_cmp++;
    if (bus.flush !== 1'b0) begin
      n_err++;
      $display("FAIL flush_width got=%b exp=0", bus.flush);
    end
    @(negedge clk);
    @(negedge clk);
    bus.fetch_req = 1'b0;
    #1;
    n_cmp++;
    if (bus.fetch_rdata !== 32'h22) begin
      n_err++;
      $display("FAIL burst_readback got=%h exp=%h", bus.fetch_rdata,
               32'h22);
    end
    @(negedge clk);
  endtask

  task automatic test_max_burst();
    logic [23:0] lgv, fgv, hv;
    int idx;
    do_reset();
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 6'd1;
    idx = 0;
    for (int c = 0; c < 24; c++) begin
      bus.load_req   = (idx < 12);
      bus.load_addr  = 6'(30 + idx);
      bus.load_wdata = 32'h100 + 32'(idx);
      bus.load_last  = (idx == 11);
      #1;
      lgv[c] = bus.load_gnt;
      fgv[c] = bus.fetch_gnt;
      hv[c]  = bus.hold_pc;
      if (bus.load_gnt) idx++;
      @(negedge clk);
    end
    n_cmp++;
    if (lgv !== 24'h0F0FF0) begin
      n_err++;
      $display("FAIL maxb_lgnt got=%h exp=0f0ff0", lgv);
    end
    n_cmp++;
    if (fgv !== 24'hF0F00E) begin
      n_err++;
      $display("FAIL maxb_fgnt got=%h exp=f0f00e", fgv);
    end
    n_cmp++;
    if (hv !== 24'h0F0FF1) begin
      n_err++;
      $display("FAIL maxb_hold got=%h exp=0f0ff1", hv);
    end
    n_cmp++;
    if (idx !== 12) begin
      n_err++;
      $display("FAIL maxb_words got=%0d exp=12", idx);
    end
    bus.load_req   = 1'b0;
    bus.load_last  = 1'b0;
    bus.fetch_addr = 6'd37;
    @(negedge clk);
    bus.fetch_req = 1'b0;
    #1;
    n_cmp++;
    if (bus.fetch_rdata !== 32'h107) begin
      n_err++;
      $display("FAIL maxb_readback got=%h exp=%h", bus.fetch_rdata,
               32'h107);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int idx;
    do_reset();
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      rst_n          = (c != 2);
      bus.load_req   = (idx < 3);
      bus.load_addr  = 6'(50 + idx);
      bus.load_wdata = 32'hC0DE_0000 + 32'(idx);
      bus.load_last  = (idx == 2);
      #1;
      if (c == 2) begin
        n_cmp++;
        if ({bus.mem_en, bus.load_gnt, bus.hold_pc} !== 3'b001) begin
          n_err++;
          $display("FAIL rstmid_cycle got=%b exp=001",
                   {bus.mem_en, bus.load_gnt, bus.hold_pc});
        end
      end
      if (c == 3) begin
        n_cmp++;
        if (bus.busy !== 1'b0) begin
          n_err++;
          $display("FAIL rstmid_busy got=%b exp=0", bus.busy);
        end
      end
      if (bus.load_gnt) idx++;
      @(negedge clk);
    end
    n_cmp++;
    if (idx !== 3) begin
      n_err++;
      $display("FAIL rstmid_words got=%0d exp=3", idx);
    end
    idle_inputs();
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 6'd51;
    @(negedge clk);
    @(negedge clk);
    bus.fetch_addr = 6'd50;
    #1;
    n_cmp++;
    if (bus.fetch_rdata !== 32'hC0DE_0001) begin
      n_err++;
      $display("FAIL rstmid_resent got=%h exp=c0de0001",
               bus.fetch_rdata);
    end
    @(negedge clk);
    bus.fetch_req = 1'b0;
    #1;
    n_cmp++;
    if (bus.fetch_rdata !== 32'hC0DE_0000) begin
      n_err++;
      $display("FAIL rstmid_first got=%h exp=c0de0000",
               bus.fetch_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_hlt();
    do_reset();
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 6'd2;
    @(negedge clk);
    #1;
    n_cmp++;
    if (bus.fetch_gnt !== 1'b1) begin
      n_err++;
      $display("FAIL hlt_pre got=%b exp=1", bus.fetch_gnt);
    end
    @(negedge clk);
    bus.hlt = 1'b1;
    #1;
    n_cmp++;
    if ({bus.fetch_gnt, bus.hold_pc, bus.mem_en,
         bus.fetch_valid} !== 4'b0001) begin
      n_err++;
      $display("FAIL hlt_ctrl got=%b exp=0001",
               {bus.fetch_gnt, bus.hold_pc, bus.mem_en,
                bus.fetch_valid});
    end
    n_cmp++;
    if (bus.fetch_rdata !== WC) begin
      n_err++;
      $display("FAIL hlt_drain got=%h exp=%h", bus.fetch_rdata, WC);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({bus.busy, bus.fetch_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL hlt_idle got=%b exp=00",
               {bus.busy, bus.fetch_valid});
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_fetch();
    test_starve();
    test_burst();
    test_max_burst();
    test_reset_mid();
    test_hlt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Arbitrates the single-port instruction memory between two requesters: the pipeline fetch side (program counter) and a program loader that writes instruction words into memory.
- Sits between the PC/fetch stage and the instruction RAM.
- Drives a PC hold signal while fetch is denied, and returns NOP (32'h00000013) on cycles with no valid fetch data.
- Bounds loader starvation and loader burst length so that neither side can lock out the other.

Parameters:
- ADDR_W, 6, instruction-memory word address width (64 words).
- DATA_W, 32, instruction width.
- MAX_BURST, 8, maximum loader writes per LOAD tenure.
- STARVE_LIMIT, 4, maximum cycles a pending loader request waits behind fetch.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- hlt  in  1  processor halted; while 1, fetch_req is treated as 0.
- fetch_req  in  1  fetch wants an instruction this cycle.
- fetch_addr  in  ADDR_W  word address (PC).
- fetch_gnt  out  1  fetch owns the memory this cycle.
- fetch_valid  out  1  fetch_rdata holds data from the previous cycle's grant.
- fetch_rdata  out  DATA_W  instruction to the pipeline.
- hold_pc  out  1  PC must not advance this cycle.
- load_req  in  1  loader write pending.
- load_addr  in  ADDR_W  write address.
- load_wdata  in  DATA_W  write data.
- load_last  in  1  final word of the loader burst.
- load_gnt  out  1  write accepted this cycle.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; synchronous read, 1-cycle latency.
- busy  out  1  state != IDLE.
- flush  out  1  one-cycle refetch pulse; see Optional Feature.

Behaviour:
- Reset values (synchronous; applied on the edge where rst_n=0):
  - state=IDLE, starve_cnt=0, burst_cnt=0, fetch_valid=0, flush=0.
  - While rst_n=0: fetch_gnt=0, load_gnt=0, mem_en=0, mem_we=0, hold_pc=1.
- States: IDLE, FETCH, LOAD. Memory port outputs are combinational from the current state:
  - FETCH: fetch_gnt=fetch_req; mem_en=fetch_gnt; mem_we=0; mem_addr=fetch_addr.
  - LOAD: load_gnt=load_req; mem_en=mem_we=load_gnt; mem_addr=load_addr; mem_wdata=load_wdata.
  - IDLE: no grants; mem_en=0.
- hold_pc = fetch_req & ~fetch_gnt.
- Read data path: fetch_valid <= fetch_gnt. fetch_rdata = mem_rdata when fetch_valid, else 32'h00000013.
- starve_cnt:
  - Increments each cycle load_req=1 and state!=LOAD; saturates at STARVE_LIMIT.
  - Clears on entry to LOAD.
  - Clears when load_req=0 outside LOAD.
- Transitions, evaluated at each rising edge using pre-edge values:
  - IDLE -> LOAD if load_req & (~fetch_req | starve_cnt>=STARVE_LIMIT-1).
  - IDLE -> FETCH if fetch_req and the LOAD condition is false.
  - IDLE -> IDLE otherwise.
  - FETCH -> LOAD if load_req & (~fetch_req | starve_cnt>=STARVE_LIMIT-1).
  - FETCH -> IDLE if ~fetch_req & ~load_req.
  - FETCH -> FETCH otherwise.
  - LOAD exit occurs when any of the following holds: (load_gnt & load_last), (load_gnt & burst_cnt==MAX_BURST-1), or ~load_req. Exit goes to FETCH if fetch_req, else IDLE.
- burst_cnt:
  - Increments per load_gnt.
  - Clears on LOAD exit.
  - Width is clog2(MAX_BURST)+1.
- Forced exit at MAX_BURST with load_req still high: the loader re-arbitrates with starve_cnt=0, so fetch gets at least STARVE_LIMIT cycles.
- Fetch to an address written by LOAD always returns the new word, because the port is single and writes precede the refetch.
- An IDLE->FETCH entry costs one hold_pc cycle.
- hlt=1 mid-FETCH: the state drops to IDLE on the next edge (unless load_req is pending). Any outstanding fetch_valid still completes.
- Reset mid-burst: the write in the reset cycle is suppressed (mem_en=0). Loader words not granted must be resent.

Optional Feature:
- Macro: IMEM_LOAD_FLUSH_EN.
- Defined:
  - flush=1 for exactly the first cycle after any LOAD exit.
  - fetch_valid is forced to 0 in that cycle.
  - The pipeline discards in-flight instructions and refetches.
- Undefined: flush is tied to 0; no squash.

Test Plan:
1. rst_n=0 two cycles, then fetch_req=1, fetch_addr=0,1,2 (advancing only when hold_pc=0), mem[0..2]=A,B,C.
   - Cycle 1: hold_pc=1.
   - Cycles 2..4: fetch_gnt=1.
   - fetch_rdata returns A, B, C one cycle after each grant; NOP when fetch_valid=0.
2. fetch_req held 1 continuously, load_req rises at cycle 0, STARVE_LIMIT=4.
   - load_gnt is first 1 at cycle 4.
   - hold_pc=1 for every LOAD cycle.
3. Loader burst of 3 words to addresses 10..12 (0x11, 0x22, 0x33) with load_last on the third, fetch idle.
   - Exactly 3 mem_we pulses, then IDLE.
   - A subsequent fetch of address 11 returns 0x22.
4. load_req held 1 for 12 words, MAX_BURST=8, fetch_req=1.
   - LOAD exits after 8 grants.
   - fetch_gnt for 4 cycles, then LOAD resumes for the remaining 4.
5. rst_n=0 during the 2nd word of a burst.
   - mem_en=0 in the reset cycle; state returns to IDLE; busy=0.
   - Loader resends the word and it is written correctly.
6. With IMEM_LOAD_FLUSH_EN defined: flush=1 for one cycle after the burst in test 3, with fetch_valid=0 that cycle. Undefined: flush stays 0.
